seven_seg_capture: RTL and testbench
====================================

// Module: seven_seg_capture
// PURPOSE
//  Receive side of the active-low multiplexed 7-segment display bus: samples segment lines and
//  digit strobes, debounces each digit dwell and decodes patterns back to hex nibbles.
//  Assembles one NUM_DIGITS-wide hex word per scan frame, with frame-valid and error flags.
//  Sits in the lab self-check harness to read back what the display drivers are showing.
// PARAMETERS
//  NUM_DIGITS     4   digit positions on the scanned bus (1..8)
//  STABLE_CYCLES  8   consecutive identical samples required before capture (>=2)
// PORTS
//  clk          in   1              single clock, rising-edge
//  rst          in   1              reset, asynchronous, active-high
//  seg_n        in   7              segments {g,f,e,d,c,b,a}, active-low (0 = lit); asynchronous
//  an_n         in   NUM_DIGITS     digit strobes, active-low, one-hot-low when valid; asynchronous
//  value        out  4*NUM_DIGITS   decoded word; digit i in value[4i+3:4i]
//  frame_valid  out  1              one-cycle pulse: value updated with a complete frame
//  frame_err    out  1              valid with frame_valid: >=1 digit in frame had an illegal pattern
//  err_mask     out  NUM_DIGITS     valid with frame_valid: per-digit illegal-pattern flags
// BEHAVIOUR
//  Reset: value=0, frame_valid=0, frame_err=0, err_mask=0.
//   Synchronizers go to all-1s (inactive). Counters, captured/err bits and slots clear.
//   Reset mid-frame discards the partial frame.
//  Input sync: seg_n and an_n each pass through a 2-flop synchronizer. All logic uses the synced copies.
//  Dwell tracking, each cycle:
//   - an_n not one-hot-low (all high or >1 low): counter:=0, no capture.
//   - one-hot-low and {an_n,seg_n} equal to previous cycle: counter increments, saturating at STABLE_CYCLES.
//   - otherwise: counter:=1, restarting the dwell.
//  Capture fires once per dwell, on the edge where the counter goes STABLE_CYCLES-1 -> STABLE_CYCLES.
//   - Legal pattern (one of 16 codes): slot[d] := nibble, err[d] := 0.
//   - Illegal pattern: slot[d] is held, err[d] := 1.
//   - In both cases captured[d] := 1.
//   - A later, different stable pattern on the same digit re-captures and overwrites.
//  Decode table (seg_n -> nibble):
//   40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8 10->9 08->A 03->B 46->C 21->D 06->E 0E->F (hex)
//  Frame completion: on the edge after captured becomes all-1s:
//   - value := all slots, err_mask := err, frame_err := |err, frame_valid := 1 for one cycle.
//   - captured and err clear on that same edge.
//   - A capture landing on the completion edge counts toward the next frame.
//  Latency: input change -> 2 sync cycles + STABLE_CYCLES -> slot write. Last slot write -> +1 -> frame_valid.
//  Segment change while strobe is held restarts the counter. Only stable values are ever captured.
//  Blanked bus (an_n all high) never completes a frame. value holds its last frame indefinitely.
// STRUCTURE
//  Package seven_seg_pkg holds:
//   - SEG_W=7 and the active-low 16-entry pattern table, shared with the display drivers.
//   - the BLANK=7'h7F constant.
//   - function is_onehot_low().
//  Sub-module seven_seg_pattern_decode (combinational): seg_n[6:0] -> nibble[3:0] + legal flag.
//  Top holds the synchronizers, dwell counter, slot/captured/err registers and frame logic.
//  Counter width: $clog2(STABLE_CYCLES+1).
// TESTING
//  1. Scan digits 0..3 with patterns 30,12,00,0E, 20 cycles each -> one frame_valid, value=16'hF853, frame_err=0.
//  2. Same scan, digit 2 shown for only STABLE_CYCLES-1 cycles -> no frame_valid until a full dwell occurs.
//  3. Digit 1 = 7'h7E (illegal) -> frame_valid with err_mask=4'b0010, frame_err=1, value[7:4] unchanged.
//  4. an_n=4'b0011 (two low) for 50 cycles -> no capture, counter 0. All-high an_n -> no frame, value held.
//  5. Assert rst after digits 0,1 captured -> outputs 0. Then a full scan -> exactly one frame with the new values.
//  6. Digit 3 changes 79->24 mid-dwell, both stable >=STABLE_CYCLES -> frame reports digit 3 = 2.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the active-low multiplexed 7-segment display bus.
// The pattern table is common to the display drivers and the capture side.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] BLANK = 7'h7F;

  // Entry i is the active-low {g,f,e,d,c,b,a} pattern that displays hex digit i.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Strobes narrower than 8 digits are padded with inactive (1) bits by the caller.
  function automatic logic is_onehot_low(input logic [7:0] an_n);
    return $onehot(~an_n);
  endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// Scanned display bus plus the decoded frame it produces.
// The master modport belongs to whoever drives the display lines and reads back the frame.
interface seven_seg_capture_if
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  logic [SEG_W-1:0]        seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    frame_valid;
  logic                    frame_err;
  logic [NUM_DIGITS-1:0]   err_mask;

  modport master (output seg_n, an_n, input value, frame_valid, frame_err, err_mask);
  modport slave  (input seg_n, an_n, output value, frame_valid, frame_err, err_mask);
endinterface

// File: rtl/seven_seg_pattern_decode.sv
// Maps an active-low segment pattern back to its hex nibble.
// Patterns outside the 16-entry table are flagged as illegal.
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg_n,
  output logic [3:0]       nibble,
  output logic             legal
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    nibble = '0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_n == SEG_TABLE[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of the scanned 7-segment bus: synchronizes, debounces each digit dwell,
// decodes it and assembles one hex word per complete scan frame.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input logic                clk,
  input logic                rst,
  seven_seg_capture_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SEG_W-1:0]            seg_s1, seg_s2, seg_prev;
  logic [NUM_DIGITS-1:0]       an_s1, an_s2, an_prev;
  logic [CW-1:0]               cnt, cnt_next;
  logic [NUM_DIGITS-1:0][3:0]  slots;
  logic [NUM_DIGITS-1:0]       captured, err, captured_base, err_base;
  logic [4*NUM_DIGITS-1:0]     value_q;
  logic                        frame_valid_q, frame_err_q;
  logic [NUM_DIGITS-1:0]       err_mask_q;

  logic [7:0]    an_pad;
  logic          onehot, same, capture, legal, frame_done;
  logic [DW-1:0] digit;
  logic [3:0]    nibble;

  seven_seg_pattern_decode u_decode (
    .seg_n  (seg_s2),
    .nibble (nibble),
    .legal  (legal)
  );

  always_comb begin
    an_pad                 = '1;
    an_pad[NUM_DIGITS-1:0] = an_s2;
    onehot                 = is_onehot_low(an_pad);
    same                   = (an_s2 == an_prev) && (seg_s2 == seg_prev);

    digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s2[i]) digit = DW'(i);
    end

    if (!onehot)                         cnt_next = '0;
    else if (!same)                      cnt_next = CW'(1);
    else if (cnt == CW'(STABLE_CYCLES))  cnt_next = cnt;
    else                                 cnt_next = cnt + 1'b1;

    // Fires only on the single edge where the dwell first reaches full length.
    capture    = onehot && same && (cnt == CW'(STABLE_CYCLES - 1));
    frame_done = &captured;

    // A completed frame clears its bookkeeping; a capture on that edge still lands below.
    captured_base = frame_done ? '0 : captured;
    err_base      = frame_done ? '0 : err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1        <= BLANK;
      seg_s2        <= BLANK;
      seg_prev      <= BLANK;
      an_s1         <= '1;
      an_s2         <= '1;
      an_prev       <= '1;
      cnt           <= '0;
      slots         <= '0;
      captured      <= '0;
      err           <= '0;
      value_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_mask_q    <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every register samples pre-edge values and a
      // later assignment to the same bit in this block overrides the earlier one.
      seg_s1   <= bus.seg_n;
      seg_s2   <= seg_s1;
      an_s1    <= bus.an_n;
      an_s2    <= an_s1;
      seg_prev <= seg_s2;
      an_prev  <= an_s2;
      cnt      <= cnt_next;

      frame_valid_q <= frame_done;
      if (frame_done) begin
        value_q     <= slots;
        err_mask_q  <= err;
        frame_err_q <= |err;
      end

      captured <= captured_base;
      err      <= err_base;
      if (capture) begin
        captured[digit] <= 1'b1;
        if (legal) begin
          slots[digit] <= nibble;
          err[digit]   <= 1'b0;
        end else begin
          err[digit]   <= 1'b1;
        end
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.err_mask    = err_mask_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: a frame-level model predicts every output each
// cycle, and literal checks after each scenario pin the model to hand-computed results.
module tb_seven_seg_capture;

  localparam int ND = 4;
  localparam int SC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_capture_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total  = 0;
  int bad    = 0;
  int frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]  m_seg_d1, m_seg_d2, m_last_seg;
  logic [3:0]  m_an_d1, m_an_d2, m_last_an;
  int          m_run;
  logic [3:0]  m_slot [ND];
  logic [ND-1:0] m_cap, m_err;
  logic [15:0] exp_value;
  logic        exp_fv, exp_ferr;
  logic [3:0]  exp_mask;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: return {1'b1, 4'h0};  7'h79: return {1'b1, 4'h1};
      7'h24: return {1'b1, 4'h2};  7'h30: return {1'b1, 4'h3};
      7'h19: return {1'b1, 4'h4};  7'h12: return {1'b1, 4'h5};
      7'h02: return {1'b1, 4'h6};  7'h78: return {1'b1, 4'h7};
      7'h00: return {1'b1, 4'h8};  7'h10: return {1'b1, 4'h9};
      7'h08: return {1'b1, 4'hA};  7'h03: return {1'b1, 4'hB};
      7'h46: return {1'b1, 4'hC};  7'h21: return {1'b1, 4'hD};
      7'h06: return {1'b1, 4'hE};  7'h0E: return {1'b1, 4'hF};
      default: return 5'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_seg_d1 = 7'h7F; m_seg_d2 = 7'h7F; m_last_seg = 7'h7F;
    m_an_d1 = '1; m_an_d2 = '1; m_last_an = '1;
    m_run = 0;
    for (int i = 0; i < ND; i++) m_slot[i] = '0;
    m_cap = '0; m_err = '0;
    exp_value = '0; exp_fv = 1'b0; exp_ferr = 1'b0; exp_mask = '0;
  endtask

  task automatic model_step();
    logic [6:0] cur_seg;
    logic [3:0] cur_an;
    logic [4:0] dec;
    int         d;
    // The logic sees the bus as it was two edges ago.
    cur_seg  = m_seg_d2;  cur_an  = m_an_d2;
    m_seg_d2 = m_seg_d1;  m_an_d2 = m_an_d1;
    m_seg_d1 = bus.seg_n; m_an_d1 = bus.an_n;

    if ($countones(~cur_an) != 1)                     m_run = 0;
    else if (cur_an == m_last_an && cur_seg == m_last_seg) m_run++;
    else                                              m_run = 1;
    m_last_an = cur_an; m_last_seg = cur_seg;

    exp_fv = (m_cap == '1);
    if (exp_fv) begin
      for (int i = 0; i < ND; i++) exp_value[4*i +: 4] = m_slot[i];
      exp_mask = m_err;
      exp_ferr = (m_err != 0);
      m_cap = '0; m_err = '0;
    end

    if (m_run == SC) begin
      d = 0;
      for (int i = 0; i < ND; i++) if (!cur_an[i]) d = i;
      dec = decode(cur_seg);
      m_cap[d] = 1'b1;
      if (dec[4]) begin m_slot[d] = dec[3:0]; m_err[d] = 1'b0; end
      else m_err[d] = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1) frames++;
      check("frame_valid", 32'(bus.frame_valid), 32'(exp_fv));
      check("value", 32'(bus.value), 32'(exp_value));
      if (exp_fv) begin
        check("err_mask", 32'(bus.err_mask), 32'(exp_mask));
        check("frame_err", 32'(bus.frame_err), 32'(exp_ferr));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    @(posedge clk);
    #2;
    bus.an_n  = an;
    bus.seg_n = seg;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic show(input int d, input logic [6:0] seg, input int n);
    drive(~(4'b0001 << d), seg, n);
  endtask

  task automatic blank(input int n);
    drive(4'hF, 7'h7F, n);
  endtask

  initial begin
    bus.an_n  = '1;
    bus.seg_n = 7'h7F;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset value", 32'(bus.value), 32'h0);
    check("reset err_mask", 32'(bus.err_mask), 32'h0);
    check("reset frame_err", 32'(bus.frame_err), 32'h0);
    blank(5);

    // 1: plain scan
    show(0, 7'h30, 20); show(1, 7'h12, 20); show(2, 7'h00, 20); show(3, 7'h0E, 20);
    blank(5);
    @(negedge clk);
    check("t1 frames", 32'(frames), 32'd1);
    check("t1 value", 32'(bus.value), 32'hF853);
    check("t1 frame_err", 32'(bus.frame_err), 32'h0);

    // 2: short dwell on digit 2 must not complete the frame
    show(0, 7'h79, 20); show(1, 7'h24, 20); show(2, 7'h19, SC - 1); show(3, 7'h10, 20);
    blank(10);
    @(negedge clk);
    check("t2 no frame", 32'(frames), 32'd1);
    show(2, 7'h19, 20);
    blank(5);
    @(negedge clk);
    check("t2 frames", 32'(frames), 32'd2);
    check("t2 value", 32'(bus.value), 32'h9421);

    // 3: illegal pattern on digit 1 keeps its old nibble
    show(0, 7'h40, 20); show(1, 7'h7E, 20); show(2, 7'h02, 20); show(3, 7'h78, 20);
    blank(5);
    @(negedge clk);
    check("t3 frames", 32'(frames), 32'd3);
    check("t3 err_mask", 32'(bus.err_mask), 32'h2);
    check("t3 frame_err", 32'(bus.frame_err), 32'h1);
    check("t3 value", 32'(bus.value), 32'h7620);

    // 4: two strobes low, then blanked bus
    drive(4'b0011, 7'h00, 50);
    @(negedge clk);
    check("t4 counter", 32'(dut.cnt), 32'h0);
    blank(50);
    @(negedge clk);
    check("t4 frames", 32'(frames), 32'd3);
    check("t4 value held", 32'(bus.value), 32'h7620);

    // 5: reset discards a partial frame
    show(0, 7'h40, 20); show(1, 7'h79, 20);
    blank(2);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("t5 value", 32'(bus.value), 32'h0);
    check("t5 frame_valid", 32'(bus.frame_valid), 32'h0);
    check("t5 err_mask", 32'(bus.err_mask), 32'h0);
    show(0, 7'h08, 20); show(1, 7'h03, 20); show(2, 7'h46, 20); show(3, 7'h21, 20);
    blank(5);
    @(negedge clk);
    check("t5 frames", 32'(frames), 32'd4);
    check("t5 value", 32'(bus.value), 32'hDCBA);

    // 6: digit 3 changes pattern mid-dwell; the later stable pattern wins
    show(3, 7'h79, 12); show(3, 7'h24, 12);
    show(0, 7'h40, 20); show(1, 7'h40, 20); show(2, 7'h40, 20);
    blank(5);
    @(negedge clk);
    check("t6 frames", 32'(frames), 32'd5);
    check("t6 digit3", 32'(bus.value[15:12]), 32'h2);
    check("t6 value", 32'(bus.value), 32'h2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
